demux_4_fifo: RTL and testbench
===============================

// Module: demux_4_fifo
// PURPOSE
//  Write-side counterpart of the 4:1 datapath multiplexer: accepts a stream of
//  {sel, data} words from one producer and delivers each word to exactly one of
//  four consumers (sel 2'b00->port 0 .. 2'b11->port 3). Words are buffered in
//  a DEPTH-entry FIFO and delivered strictly in arrival order over valid/ready.
//  Sits between the CPU store path and the memory-mapped write sinks (RAM, LED,
//  seven-segment display, timer).
// PARAMETERS
//  WIDTH  32  data width in bits
//  DEPTH  4   FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous reset, active-high
//  in_valid   in   1              producer offers a word
//  in_ready   out  1              block can accept a word
//  in_sel     in   2              destination port of the offered word
//  in_data    in   WIDTH          offered data
//  out_valid  out  4              one-hot; bit N: head word is for port N
//  out_ready  in   4              bit N: port N accepts a word this cycle
//  dataout    out  WIDTH          head word data, shared by all four ports
//  level      out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (async, rst=1): read/write pointers=0, level=0, out_valid=4'b0000,
//    dataout=0, in_ready=0 while rst is high; FIFO contents discarded.
//    Mid-transfer reset drops all words; no word is delivered after reset
//    deasserts until a new push.
//  - in_ready = !rst && (level < DEPTH). in_ready does not depend on out_ready;
//    when full, a same-cycle pop does NOT allow a push.
//  - Push: in_valid && in_ready at a rising edge stores {in_sel, in_data} at
//    wr_ptr; wr_ptr increments mod DEPTH. in_sel/in_data ignored otherwise.
//  - Head presentation: level>0 -> out_valid = 1 << head_sel, dataout = head
//    data; level==0 -> out_valid=0, dataout=0. Outputs derive from stored
//    state only (no combinational in->out path).
//  - Pop: out_valid[N] && out_ready[N] at an edge; rd_ptr increments mod
//    DEPTH. out_ready bits of non-selected ports are ignored.
//  - Push and pop in the same cycle: level unchanged, both pointers advance.
//  - Latency: word pushed at edge k into an empty FIFO is presented in the
//    cycle after edge k; minimum 1 cycle in->out, throughput 1 word/cycle.
//  - Ordering: strict FIFO across all ports. A stalled head blocks later words
//    for other ports (head-of-line blocking is intended; writes stay ordered).
//  - Once out_valid[N] is high, it and dataout hold stable until popped or reset.
//  - Pointer wrap-around: DEPTH-1 -> 0 with no gap or duplicated word.
// TESTING
//  1 Reset: assert rst mid-cycle with 3 words queued -> out_valid=0, level=0,
//    dataout=0 immediately (no clock edge); in_ready=1 after rst drops.
//  2 Single word: push sel=2, data=32'hDEAD_BEEF, out_ready=4'b1111 ->
//    next cycle out_valid=4'b0100, dataout=DEAD_BEEF; popped at that edge, level=0.
//  3 Fill: out_ready=0, push 5 words -> first 4 accepted, in_ready=0 after
//    4th, level=4; 5th held by producer and accepted after first pop.
//  4 Head-of-line: queue {sel0,A},{sel1,B}; out_ready=4'b0010 for 5 cycles ->
//    out_valid stays 4'b0001 with A; then 4'b0011 -> A then B on consecutive cycles.
//  5 Streaming: 12 back-to-back pushes with rotating sel 0..3, out_ready=4'b1111
//    -> 1 word/cycle, order and ports match, pointers wrap 3 times, level<=1.
//  6 Full + pop: level=4, in_valid=1, pop at same edge -> no push that cycle,
//    level=3; push succeeds the following edge.

Source files
------------

// File: rtl/demux_4_fifo.sv
// demux_4_fifo: buffers {sel, data} words from one producer in a small FIFO
// and hands each word, in strict arrival order, to one of four consumers over
// valid/ready. Head-of-line blocking is intentional so that writes stay ordered.
module demux_4_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_sel,
    input  logic [WIDTH-1:0]         in_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [WIDTH-1:0]         dataout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Storage holds the destination select alongside the data word.
    logic [WIDTH+1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]    level_reg, level_next;

    logic             push;
    logic             pop;
    logic             has_word;
    logic [1:0]       head_sel;
    logic [WIDTH-1:0] head_data;

    assign has_word              = (level_reg != '0);
    assign {head_sel, head_data} = mem[rd_ptr_reg];

    // in_ready looks only at occupancy: a pop in the same cycle never frees a slot early.
    assign in_ready = !rst && (level_reg < FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign pop      = |(out_valid & out_ready);

    // One-hot head decode; only the addressed port sees valid.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign out_valid[gi] = has_word && (head_sel == 2'(gi));
        end
    endgenerate

    // Empty FIFO presents zero rather than stale storage contents.
    assign dataout = has_word ? head_data : '0;
    assign level   = level_reg;

    // Next-state pointers and occupancy from this cycle's push/pop handshakes.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // Pointer and occupancy registers; reset discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Word storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_sel, in_data};
        end
    end

endmodule

// File: tb/tb_demux_4_fifo.sv
// Testbench for demux_4_fifo: directed scenarios plus random traffic, checked
// by a negedge monitor against a queue-based reference model.
module tb_demux_4_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] dataout;
    logic [2:0]       level;

    int checks = 0;
    int errors = 0;

    // Reference model: every word accepted and not yet delivered, oldest first.
    logic [WIDTH+1:0] sbq [$];

    demux_4_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .dataout(dataout), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT to the model before each rising edge, then advance the model.
    always @(negedge clk) begin
        logic [3:0]       exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic             exp_ready;
        if (rst) begin
            sbq.delete();
        end else begin
            exp_ready = (sbq.size() < DEPTH);
            exp_valid = 4'b0000;
            exp_data  = '0;
            if (sbq.size() > 0) begin
                exp_valid = 4'b0001 << sbq[0][WIDTH+1:WIDTH];
                exp_data  = sbq[0][WIDTH-1:0];
            end
            chk("mon_in_ready", 64'(in_ready), 64'(exp_ready));
            chk("mon_level", 64'(level), 64'(sbq.size()));
            chk("mon_out_valid", 64'(out_valid), 64'(exp_valid));
            chk("mon_dataout", 64'(dataout), 64'(exp_data));
            if (sbq.size() > 0 && out_ready[sbq[0][WIDTH+1:WIDTH]]) begin
                $display("pop  port=%0d data=%08h", sbq[0][WIDTH+1:WIDTH], sbq[0][WIDTH-1:0]);
                void'(sbq.pop_front());
            end
            if (in_valid && exp_ready) begin
                $display("push sel=%0d data=%08h", in_sel, in_data);
                sbq.push_back({in_sel, in_data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until the block takes it (bounded wait).
    task automatic push_word(input logic [1:0] sel, input logic [WIDTH-1:0] data);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("push_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic drain();
        out_ready = 4'b1111;
        for (int i = 0; i < 50 && level != 0; i++) step();
        chk("drain_level", 64'(level), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] a_word;
        logic [WIDTH-1:0] b_word;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_dataout", 64'(dataout), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 64'(in_ready), 64'd1);

        // Single word to port 2, consumer always ready.
        out_ready = 4'b1111;
        push_word(2'd2, 32'hDEAD_BEEF);
        chk("single_valid", 64'(out_valid), 64'b0100);
        chk("single_data", 64'(dataout), 64'hDEAD_BEEF);
        step();
        chk("single_level", 64'(level), 64'd0);
        chk("single_empty", 64'(out_valid), 64'd0);

        // Fill: fifth word waits until the first pop frees a slot.
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) push_word(2'(i), 32'h1000 + 32'(i));
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        fork
            push_word(2'd3, 32'h1004);
            begin
                repeat (3) step();
                out_ready = 4'b1111;
            end
        join
        drain();

        // Full plus same-edge pop: no push that edge, push on the next.
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) push_word(2'(3 - i), 32'h2000 + 32'(i));
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 32'h2004;
        out_ready = 4'b1111;
        step();
        chk("fullpop_level1", 64'(level), 64'd3);
        step();
        chk("fullpop_level2", 64'(level), 64'd3);
        in_valid = 1'b0;
        drain();

        // Head-of-line blocking: port 1 ready but head belongs to port 0.
        a_word    = $urandom;
        b_word    = $urandom;
        out_ready = 4'b0000;
        push_word(2'd0, a_word);
        push_word(2'd1, b_word);
        out_ready = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hol_valid", 64'(out_valid), 64'b0001);
            chk("hol_data", 64'(dataout), 64'(a_word));
        end
        out_ready = 4'b0011;
        step();
        chk("hol_b_valid", 64'(out_valid), 64'b0010);
        chk("hol_b_data", 64'(dataout), 64'(b_word));
        step();
        chk("hol_done", 64'(out_valid), 64'd0);

        // Streaming: back-to-back pushes with rotating ports, wrapping pointers.
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_sel  = 2'(i % 4);
            in_data = $urandom;
            step();
            chk("stream_level_le1", 64'(level <= 3'd1), 64'd1);
        end
        in_valid = 1'b0;
        drain();

        // Reset with three words queued: outputs clear without a clock edge.
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) push_word(2'(i), $urandom);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_dataout", 64'(dataout), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        out_ready = 4'b1111;
        step();
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("postrst_no_word", 64'(out_valid), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            step();
        end
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
